uart_transmitter: RTL and testbench

Serializes parallel data words onto the UART TX line as asynchronous frames: start bit, DBITS data bits LSB-first, optional parity, then stop bit(s). It is the transmit-side counterpart of the UART receiver. It shares the 16x-oversampling `sample_tick` from the system baud-rate generator and takes words from the TX FIFO through a valid/ready handshake. A one-entry holding register allows back-to-back frames with no idle gap on the line.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_transmitter.sv | 166 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling ratio and frame defaults.
package uart_pkg;

    // 16x oversampling: one bit period is this many sample ticks
    localparam int OVERSAMPLE = 16;

    // Frame defaults shared by the transmitter and the receiver
    localparam int DEF_DBITS   = 8;
    localparam int DEF_SB_TICK = 16;

    // 3-bit state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DBITS data bits LSB first, optional parity,
// stop period. A one-entry holding register lets the next word be queued
// while a frame is on the line so consecutive frames have no idle gap.
//
// Handshake: a word is taken on any rising edge where tx_valid and tx_ready
// are both high; tx_ready is simply "holding register empty", so it never
// depends on tx_valid and drops the cycle after an accept.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DBITS      = DEF_DBITS,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             sample_tick,
    input  logic [DBITS-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam logic [4:0] TICK_LAST = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBITS - 1);
    localparam logic       ODD_SENSE = (PARITY_ODD != 0);

    tx_state_t        state;
    logic [4:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [DBITS-1:0] shift_reg;
    logic [DBITS-1:0] shift_next;
    logic [DBITS-1:0] hold_data;
    logic             hold_full;
    logic             parity_bit;
    logic             tx_reg;
    logic             done_reg;
    logic             stop_end;
    logic             start_frame;
    logic             accept;

    // Last tick of the stop period; the frame ends on this edge
    assign stop_end    = (state == STOP) && sample_tick && (tick_cnt == STOP_LAST);
    // The FSM takes the held word from IDLE or straight out of the stop period
    assign start_frame = hold_full && ((state == IDLE) || stop_end);
    assign accept      = tx_valid && !hold_full;
    assign shift_next  = shift_reg >> 1;

    assign tx_ready = !hold_full;
    assign tx       = tx_reg;
    assign tx_busy  = (state != IDLE);
    assign tx_done  = done_reg;

    // Holding register: filled on accept, drained when the FSM starts a frame
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (start_frame) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end
    end

    // Frame FSM with registered line output and done pulse
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (hold_full) begin
                        shift_reg  <= hold_data;
                        parity_bit <= (^hold_data) ^ ODD_SENSE;
                        tick_cnt   <= '0;
                        tx_reg     <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            tx_reg   <= shift_reg[0];
                            state    <= DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= shift_next;
                            if (bit_cnt == BIT_LAST) begin
                                if (PARITY_EN != 0) begin
                                    tx_reg <= parity_bit;
                                    state  <= PARITY;
                                end else begin
                                    tx_reg <= 1'b1;
                                    state  <= STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                tx_reg  <= shift_next[0];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            tx_reg   <= 1'b1;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            tick_cnt <= '0;
                            done_reg <= 1'b1;
                            if (hold_full) begin
                                shift_reg  <= hold_data;
                                parity_bit <= (^hold_data) ^ ODD_SENSE;
                                tx_reg     <= 1'b0;
                                state      <= START;
                            end else begin
                                tx_reg <= 1'b1;
                                state  <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    tx_reg <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: four instances cover the default
// frame, even and odd parity, and a two-stop-bit frame. The line is sampled
// on every sample_tick so each bit shows up as a run of identical samples.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_tick = 1'b0;
    logic [1:0] div = 2'd0;
    logic [7:0] tx_data;
    logic [3:0] valid_v;
    logic [3:0] ready_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int checks   = 0;
    int failures = 0;
    int tick_count = 0;
    int done_cnt[4]  = '{default: 0};
    int done_tick[4] = '{default: 0};

    // Clock and a tick every fourth cycle
    always #5 clk = ~clk;

    always @(posedge clk) begin
        div         <= div + 2'd1;
        sample_tick <= (div == 2'd3);
    end

    // Count ticks and record done pulses per instance
    always @(negedge clk) begin
        if (sample_tick) tick_count <= tick_count + 1;
        for (int i = 0; i < 4; i++) begin
            if (done_v[i]) begin
                done_cnt[i]  <= done_cnt[i] + 1;
                done_tick[i] <= tick_count;
            end
        end
    end

    uart_transmitter #(.DBITS(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_def (
        .clk_100MHz(clk), .reset_n(reset_n), .sample_tick(sample_tick), .tx_data(tx_data),
        .tx_valid(valid_v[0]), .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]),
        .tx_done(done_v[0]));

    uart_transmitter #(.DBITS(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
        .clk_100MHz(clk), .reset_n(reset_n), .sample_tick(sample_tick), .tx_data(tx_data),
        .tx_valid(valid_v[1]), .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]),
        .tx_done(done_v[1]));

    uart_transmitter #(.DBITS(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
        .clk_100MHz(clk), .reset_n(reset_n), .sample_tick(sample_tick), .tx_data(tx_data),
        .tx_valid(valid_v[2]), .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]),
        .tx_done(done_v[2]));

    uart_transmitter #(.DBITS(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_sb (
        .clk_100MHz(clk), .reset_n(reset_n), .sample_tick(sample_tick), .tx_data(tx_data),
        .tx_valid(valid_v[3]), .tx_ready(ready_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]),
        .tx_done(done_v[3]));

    task automatic chk(input string tag, input logic [175:0] obs, input logic [175:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected per-tick line samples for one frame
    function automatic logic [175:0] frame_model(input logic [7:0] d, input int pe,
                                                 input int po, input int sb);
        logic [175:0] f;
        int           n;
        f = '0;
        n = 16;
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < 16; k++) begin
                f[n] = d[b];
                n++;
            end
        if (pe != 0)
            for (int k = 0; k < 16; k++) begin
                f[n] = (^d) ^ (po != 0);
                n++;
            end
        for (int k = 0; k < sb; k++) begin
            f[n] = 1'b1;
            n++;
        end
        return f;
    endfunction

    // Present a word from the current negedge until it is accepted
    task automatic send(input int idx, input logic [7:0] d);
        int guard = 0;
        tx_data      = d;
        valid_v[idx] = 1'b1;
        while (ready_v[idx] !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        assert (guard < 5000)
        else begin
            failures++;
            $error("FAIL send_timeout: inst %0d waited %0d cycles, limit 5000", idx, guard);
        end
        @(negedge clk);
        valid_v[idx] = 1'b0;
    endtask

    // Wait for a start bit, then sample tx on each tick for nticks ticks
    task automatic capture(input int idx, input int nticks, output logic [175:0] got,
                           output int busy_low);
        int guard = 0;
        int n = 0;
        got      = '0;
        busy_low = 0;
        while (tx_v[idx] !== 1'b0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (n < nticks && guard < 5000) begin
            if (sample_tick === 1'b1) begin
                got[n] = tx_v[idx];
                if (busy_v[idx] !== 1'b1) busy_low++;
                n++;
            end
            if (n < nticks) begin
                @(negedge clk);
                guard++;
            end
        end
        checks++;
        assert (n == nticks)
        else begin
            failures++;
            $error("FAIL capture_timeout: inst %0d got %0d ticks, needed %0d", idx, n, nticks);
        end
    endtask

    // Cycle after the final stop tick: done pulse and the next line state
    task automatic post_frame(input int idx, input logic exp_tx, input logic exp_busy,
                              input string tag);
        @(negedge clk);
        chk({tag, "_done"}, done_v[idx], 1'b1);
        chk({tag, "_tx_next"}, tx_v[idx], exp_tx);
        chk({tag, "_busy_next"}, busy_v[idx], exp_busy);
    endtask

    initial begin
        logic [175:0] g, g1, g2, g3;
        int bl, bl1, bl2, bl3, db, t1, guard, bad;

        reset_n = 1'b0;
        valid_v = 4'h0;
        tx_data = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_tx", tx_v, 4'hF);
        chk("rst_ready", ready_v, 4'hF);
        chk("rst_busy", busy_v, 4'h0);
        chk("rst_done", done_v, 4'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx", tx_v, 4'hF);
        chk("idle_ready", ready_v, 4'hF);

        // Single 0x55 frame from idle
        db = done_cnt[0];
        fork
            send(0, 8'h55);
            capture(0, 160, g, bl);
        join
        chk("a_frame", g, frame_model(8'h55, 0, 0, 16));
        chk("a_busy_low", bl, 0);
        post_frame(0, 1'b1, 1'b0, "a");
        @(negedge clk);
        chk("a_done_count", done_cnt[0], db + 1);
        chk("a_ready", ready_v[0], 1'b1);

        // 0xA5 then 0x3C, second queued while the first is in DATA
        db = done_cnt[0];
        t1 = 0;
        fork
            begin
                send(0, 8'hA5);
                repeat (80) @(negedge clk);
                chk("b_busy_mid", busy_v[0], 1'b1);
                chk("b_ready_mid", ready_v[0], 1'b1);
                send(0, 8'h3C);
                chk("b_ready_held", ready_v[0], 1'b0);
            end
            begin
                capture(0, 160, g1, bl1);
                post_frame(0, 1'b0, 1'b1, "b1");
                capture(0, 160, g2, bl2);
                post_frame(0, 1'b1, 1'b0, "b2");
            end
            begin
                guard = 0;
                while (done_cnt[0] != db + 1 && guard < 5000) begin
                    @(negedge clk);
                    guard++;
                end
                t1 = done_tick[0];
            end
        join
        @(negedge clk);
        chk("b_frame1", g1, frame_model(8'hA5, 0, 0, 16));
        chk("b_frame2", g2, frame_model(8'h3C, 0, 0, 16));
        chk("b_busy_low", bl1 + bl2, 0);
        chk("b_done_count", done_cnt[0], db + 2);
        chk("b_done_spacing", done_tick[0] - t1, 160);

        // Even parity on 0x07: parity bit 1, 176-tick frame
        fork
            send(1, 8'h07);
            capture(1, 176, g, bl);
        join
        chk("c_frame", g, frame_model(8'h07, 1, 0, 16));
        chk("c_parity_bit", g[144], 1'b1);
        post_frame(1, 1'b1, 1'b0, "c");

        // Odd parity on 0x07: parity bit 0
        fork
            send(2, 8'h07);
            capture(2, 176, g, bl);
        join
        chk("d_frame", g, frame_model(8'h07, 1, 1, 16));
        chk("d_parity_bit", g[144], 1'b0);
        post_frame(2, 1'b1, 1'b0, "d");

        // Two stop bits on 0xFF: 32 stop ticks then done
        fork
            send(3, 8'hFF);
            capture(3, 176, g, bl);
        join
        chk("e_frame", g, frame_model(8'hFF, 0, 0, 32));
        chk("e_stop_run", g[175:144], 32'hFFFF_FFFF);
        chk("e_start_run", g[15:0], 16'h0000);
        post_frame(3, 1'b1, 1'b0, "e");

        // Holding register full during a frame with the third word waiting
        db = done_cnt[0];
        fork
            begin
                send(0, 8'h12);
                send(0, 8'h34);
                send(0, 8'h56);
                chk("f_no_early_accept", done_cnt[0], db + 1);
            end
            begin
                capture(0, 160, g1, bl1);
                post_frame(0, 1'b0, 1'b1, "f1");
                capture(0, 160, g2, bl2);
                post_frame(0, 1'b0, 1'b1, "f2");
                capture(0, 160, g3, bl3);
                post_frame(0, 1'b1, 1'b0, "f3");
            end
        join
        chk("f_frame1", g1, frame_model(8'h12, 0, 0, 16));
        chk("f_frame2", g2, frame_model(8'h34, 0, 0, 16));
        chk("f_frame3", g3, frame_model(8'h56, 0, 0, 16));
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
        end
        chk("f_idle_after", bad, 0);
        chk("f_done_count", done_cnt[0], db + 3);

        // Reset in the middle of DATA with a word held
        send(0, 8'h81);
        guard = 0;
        while (tx_v[0] !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (120) @(negedge clk);
        send(0, 8'h42);
        chk("g_held_ready", ready_v[0], 1'b0);
        chk("g_busy_mid", busy_v[0], 1'b1);
        reset_n = 1'b0;
        #1;
        chk("g_rst_tx", tx_v[0], 1'b1);
        chk("g_rst_ready", ready_v[0], 1'b1);
        chk("g_rst_busy", busy_v[0], 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
        end
        chk("g_idle_after_reset", bad, 0);
        fork
            send(0, 8'h99);
            capture(0, 160, g, bl);
        join
        chk("g_frame_after", g, frame_model(8'h99, 0, 0, 16));
        post_frame(0, 1'b1, 1'b0, "g");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
